parking_duration_ctrl: RTL

Controller for the parking-lot timing datapath. Keeps a free-running 8-bit time base and a per-slot entry-time store, serves entry and exit requests through a one-at-a-time handshake, and sequences the shared subtractor. On exit it computes duration = time_out − time_in (mod 256) and the fee, then frees the slot.

---
 rtl/parking_duration_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/parking_duration_ctrl.sv
// Parking-lot timing controller: free-running time base, per-slot entry-time
// store, one-at-a-time entry/exit handshake and duration/fee sequencing.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | sample requests; exit has priority over entry
// ENT    | entry acknowledged, ent_slot/occupancy already updated
// LOAD   | latch time_in from slot store and time_out from time base
// CALC   | duration = time_out - time_in (mod 2^TIME_W), fee computed
// DONE   | dur_valid/ext_ack pulse, slot already freed
// ERR    | ext_err pulse for an exit on an unoccupied slot
module parking_duration_ctrl #(
   parameter int SLOTS  = 8,
   parameter int SLOT_W = 3,
   parameter int TIME_W = 8,
   parameter int RATE   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              ent_req,
   output logic              ent_ack,
   output logic [SLOT_W-1:0] ent_slot,
   output logic              full,
   input  logic              ext_req,
   input  logic [SLOT_W-1:0] ext_slot,
   output logic              ext_ack,
   output logic              ext_err,
   output logic              dur_valid,
   output logic [TIME_W-1:0] duration,
   output logic [15:0]       fee,
   output logic [SLOT_W:0]   occupancy,
   output logic [TIME_W-1:0] cur_time
);

   localparam logic [SLOT_W:0]   SLOTS_N  = (SLOT_W+1)'(SLOTS);
   localparam logic [SLOT_W:0]   OCC_ONE  = (SLOT_W+1)'(1);
   localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_ENT, S_LOAD, S_CALC, S_DONE, S_ERR
   } state_t;

   state_t            state;
   logic [SLOTS-1:0]  occupied;
   logic [TIME_W-1:0] entry_time [SLOTS];
   logic [SLOT_W-1:0] exit_slot;
   logic [TIME_W-1:0] time_in;
   logic [TIME_W-1:0] time_out;
   logic [SLOT_W-1:0] free_slot;
   logic              free_found;
   logic [TIME_W-1:0] diff;
   logic [TIME_W-1:0] bill_units;

   // Lowest-index free slot; loop runs high to low so the lowest wins.
   always_comb begin
      free_slot  = '0;
      free_found = 1'b0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!occupied[i]) begin
            free_slot  = SLOT_W'(i);
            free_found = 1'b1;
         end
      end
   end

   // Shared subtractor; a zero-length stay still bills one unit.
   always_comb begin
      diff       = time_out + ~time_in + TIME_ONE;
      bill_units = (diff == '0) ? TIME_ONE : diff;
   end

   assign full = (occupancy == SLOTS_N);

   // Free-running time base, independent of the handshake FSM.
   always_ff @(posedge clk) begin
      if (reset)     cur_time <= '0;
      else if (tick) cur_time <= cur_time + TIME_ONE;
   end

   // Handshake FSM with the slot store and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         occupied  <= '0;
         for (int i = 0; i < SLOTS; i++) entry_time[i] <= '0;
         exit_slot <= '0;
         time_in   <= '0;
         time_out  <= '0;
         ent_ack   <= 1'b0;
         ent_slot  <= '0;
         ext_ack   <= 1'b0;
         ext_err   <= 1'b0;
         dur_valid <= 1'b0;
         duration  <= '0;
         fee       <= '0;
         occupancy <= '0;
      end else begin
         ent_ack   <= 1'b0;
         ext_ack   <= 1'b0;
         ext_err   <= 1'b0;
         dur_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ext_req) begin
                  exit_slot <= ext_slot;
                  if (occupied[ext_slot]) begin
                     state <= S_LOAD;
                  end else begin
                     ext_err <= 1'b1;
                     state   <= S_ERR;
                  end
               end else if (ent_req && !full && free_found) begin
                  entry_time[free_slot] <= cur_time;
                  occupied[free_slot]   <= 1'b1;
                  ent_slot              <= free_slot;
                  ent_ack               <= 1'b1;
                  occupancy             <= occupancy + OCC_ONE;
                  state                 <= S_ENT;
               end
            end
            S_ENT:  state <= S_IDLE;
            S_LOAD: begin
               // cur_time register is the pre-increment value even on a tick.
               time_in  <= entry_time[exit_slot];
               time_out <= cur_time;
               state    <= S_CALC;
            end
            S_CALC: begin
               // Results, pulses and slot release all land together in DONE.
               duration            <= diff;
               fee                 <= 16'(bill_units) * 16'(RATE);
               dur_valid           <= 1'b1;
               ext_ack             <= 1'b1;
               occupied[exit_slot] <= 1'b0;
               occupancy           <= occupancy - OCC_ONE;
               state               <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            S_ERR:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
